// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: register-port sequencer for the UART receiver.
// Programs the baud period, enables RXEN, polls the control register and
// drains received bytes to a valid/ready consumer. Overrun is recovered by
// cycling RXEN. Frame-error and overrun counts saturate at all-ones.
// Optional build macro DROP_ERR_EN: bytes with a frame error are counted but
// not delivered, and m_err is tied low.
module uart_rx_ctrl #(
    parameter logic [7:0] PERIOD_DEF  = 8'h1A,
    parameter int         POLL_GAP    = 4,
    parameter int         RECOVER_CYC = 8,
    parameter int         CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [7:0]       cfg_period,
    output logic [2:0]       u_addr,
    output logic             u_wren,
    output logic             u_rden,
    output logic [7:0]       u_wdata,
    input  logic [8:0]       u_rdata,
    output logic [7:0]       m_data,
    output logic             m_err,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             running,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] ovr_cnt
);

    localparam logic [2:0] A_PERIOD = 3'b100;
    localparam logic [2:0] A_RXDATA = 3'b101;
    localparam logic [2:0] A_CTRL   = 3'b111;

    // One shared wait counter serves both the poll gap and the recovery hold.
    localparam int WAIT_MAX = (POLL_GAP > RECOVER_CYC) ? POLL_GAP : RECOVER_CYC;
    localparam int WAIT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [WAIT_W-1:0] GAP_LAST = (POLL_GAP > 0) ? WAIT_W'(POLL_GAP - 1) : '0;
    localparam logic [WAIT_W-1:0] RCV_LAST = WAIT_W'(RECOVER_CYC - 1);

    typedef enum logic [3:0] {
        IDLE, CFG_P, CFG_E, GAP, POLL_A, POLL_B,
        RD_A, RD_B, DLV, OVR_DIS, OVR_WT, STOP
    } state_t;

    state_t            state, state_nxt, gap_tgt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [7:0]        period_eff;

    // Counter increment that holds once every bit is set.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign period_eff = (cfg_period == 8'h00) ? PERIOD_DEF : cfg_period;
    assign m_valid    = (state == DLV);

    // With no poll gap the GAP state is skipped; enable is checked on the way.
    always_comb begin
        gap_tgt = GAP;
        if (POLL_GAP == 0) begin
            gap_tgt = enable ? POLL_A : STOP;
        end
    end

    // State register; an async reset drops every strobe immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Wait counter restarts on every state change and counts up while a state holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state_nxt != state) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    // Next-state decode and bus strobes; reads hold u_addr across both cycles.
    always_comb begin
        state_nxt = state;
        u_addr    = 3'b000;
        u_wren    = 1'b0;
        u_rden    = 1'b0;
        u_wdata   = 8'h00;
        case (state)
            IDLE: begin
                if (enable) state_nxt = CFG_P;
            end
            CFG_P: begin
                u_wren    = 1'b1;
                u_addr    = A_PERIOD;
                u_wdata   = period_eff;
                state_nxt = CFG_E;
            end
            CFG_E: begin
                u_wren    = 1'b1;
                u_addr    = A_CTRL;
                u_wdata   = 8'h01;
                state_nxt = gap_tgt;
            end
            GAP: begin
                if (!enable)                   state_nxt = STOP;
                else if (wait_cnt == GAP_LAST) state_nxt = POLL_A;
            end
            POLL_A: begin
                u_rden    = 1'b1;
                u_addr    = A_CTRL;
                state_nxt = POLL_B;
            end
            POLL_B: begin
                u_addr = A_CTRL;
                // Overrun wins over pending data; the FIFO contents are abandoned.
                if (u_rdata[2])      state_nxt = OVR_DIS;
                else if (u_rdata[1]) state_nxt = RD_A;
                else                 state_nxt = gap_tgt;
            end
            RD_A: begin
                u_rden    = 1'b1;
                u_addr    = A_RXDATA;
                state_nxt = RD_B;
            end
            RD_B: begin
                u_addr    = A_RXDATA;
                state_nxt = DLV;
`ifdef DROP_ERR_EN
                if (u_rdata[8]) state_nxt = gap_tgt;
`endif
            end
            DLV: begin
                if (m_ready) state_nxt = gap_tgt;
            end
            OVR_DIS: begin
                u_wren    = 1'b1;
                u_addr    = A_CTRL;
                u_wdata   = 8'h00;
                state_nxt = OVR_WT;
            end
            OVR_WT: begin
                if (wait_cnt == RCV_LAST) state_nxt = enable ? CFG_E : IDLE;
            end
            STOP: begin
                u_wren    = 1'b1;
                u_addr    = A_CTRL;
                u_wdata   = 8'h00;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // RXEN mirror: set by the enable write, cleared by either disable write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            running <= 1'b0;
        end else if (state == CFG_E) begin
            running <= 1'b1;
        end else if (state == OVR_DIS || state == STOP) begin
            running <= 1'b0;
        end
    end

    // Capture the received byte at the end of the second read cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_data <= 8'h00;
        end else if (state == RD_B) begin
            m_data <= u_rdata[7:0];
        end
    end

`ifdef DROP_ERR_EN
    assign m_err = 1'b0;
`else
    // Frame-error flag travels with its byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_err <= 1'b0;
        end else if (state == RD_B) begin
            m_err <= u_rdata[8];
        end
    end
`endif

    // Saturating frame-error and overrun counters; cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt <= '0;
            ovr_cnt <= '0;
        end else begin
            if (state == RD_B && u_rdata[8]) err_cnt <= sat_inc(err_cnt);
            if (state == OVR_DIS)            ovr_cnt <= sat_inc(ovr_cnt);
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a small receiver register model.
module tb_uart_rx_ctrl;

    localparam int CNT_W       = 8;
    localparam int RECOVER_CYC = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic [7:0]       cfg_period;
    logic [2:0]       u_addr;
    logic             u_wren;
    logic             u_rden;
    logic [7:0]       u_wdata;
    logic [8:0]       u_rdata = 9'h000;
    logic [7:0]       m_data;
    logic             m_err;
    logic             m_valid;
    logic             m_ready;
    logic             running;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] ovr_cnt;

    uart_rx_ctrl #(
        .PERIOD_DEF (8'h1A),
        .POLL_GAP   (4),
        .RECOVER_CYC(RECOVER_CYC),
        .CNT_W      (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .cfg_period(cfg_period),
        .u_addr    (u_addr),
        .u_wren    (u_wren),
        .u_rden    (u_rden),
        .u_wdata   (u_wdata),
        .u_rdata   (u_rdata),
        .m_data    (m_data),
        .m_err     (m_err),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .running   (running),
        .err_cnt   (err_cnt),
        .ovr_cnt   (ovr_cnt)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [2:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        wr_q[$];
    logic [8:0] ctrl_q[$];
    logic [8:0] data_q[$];
    int cyc = 0, rd_data_cnt = 0, rd_ctrl_cnt = 0, both_cnt = 0, valid_cyc = 0;
    int n_vec = 0, n_bad = 0;

    // Receiver model: logs bus traffic and answers reads mid cycle A.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (u_wren) wr_q.push_back('{cyc, u_addr, u_wdata});
        if (u_wren && u_rden) both_cnt++;
        if (m_valid) valid_cyc++;
        if (u_rden && u_addr == 3'b111) begin
            rd_ctrl_cnt++;
            u_rdata = (ctrl_q.size() > 0) ? ctrl_q.pop_front() : 9'h001;
        end else if (u_rden && u_addr == 3'b101) begin
            rd_data_cnt++;
            u_rdata = (data_q.size() > 0) ? data_q.pop_front() : 9'h000;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; cfg_period = 8'h00; m_ready = 1'b1;
        tick(3);
        n_vec++; if (u_wren !== 1'b0) begin n_bad++; $display("FAIL reset_wren: got %b want 0", u_wren); end
        n_vec++; if (u_rden !== 1'b0) begin n_bad++; $display("FAIL reset_rden: got %b want 0", u_rden); end
        n_vec++; if (u_addr !== 3'b000) begin n_bad++; $display("FAIL reset_addr: got %b want 000", u_addr); end
        n_vec++; if ({m_valid, running, m_err, m_data} !== 11'h0) begin n_bad++; $display("FAIL reset_outs: got %h want 0", {m_valid, running, m_err, m_data}); end
        n_vec++; if ({err_cnt, ovr_cnt} !== '0) begin n_bad++; $display("FAIL reset_cnts: got %h want 0", {err_cnt, ovr_cnt}); end
        reset = 1'b0;
        wr_q.delete();
        tick(5);
        n_vec++; if (wr_q.size() !== 0) begin n_bad++; $display("FAIL idle_no_write: got %0d writes want 0", wr_q.size()); end
    endtask

    task automatic test_config();
        wr_q.delete();
        cfg_period = 8'h00;
        enable = 1'b1;
        for (int i = 0; i < 10 && wr_q.size() < 2; i++) tick(1);
        n_vec++;
        if (wr_q.size() < 2) begin
            n_bad++; $display("FAIL cfg_timeout: got %0d writes want 2", wr_q.size());
        end else begin
            if ({wr_q[0].addr, wr_q[0].data} !== {3'b100, 8'h1A}) begin n_bad++; $display("FAIL cfg_period_wr: got %b/%h want 100/1a", wr_q[0].addr, wr_q[0].data); end
            n_vec++; if ({wr_q[1].addr, wr_q[1].data} !== {3'b111, 8'h01}) begin n_bad++; $display("FAIL cfg_rxen_wr: got %b/%h want 111/01", wr_q[1].addr, wr_q[1].data); end
            n_vec++; if (wr_q[1].cyc - wr_q[0].cyc !== 1) begin n_bad++; $display("FAIL cfg_back2back: got gap %0d want 1", wr_q[1].cyc - wr_q[0].cyc); end
        end
        tick(1);
        n_vec++; if (running !== 1'b1) begin n_bad++; $display("FAIL cfg_running: got %b want 1", running); end
    endtask

    task automatic test_read();
        int  rd0, vc0;
        bit  seen;
        rd0 = rd_data_cnt; vc0 = valid_cyc; seen = 0;
        m_ready = 1'b1;
        ctrl_q.push_back(9'h003);
        data_q.push_back(9'h041);
        for (int i = 0; i < 40 && !seen; i++) begin tick(1); if (m_valid) seen = 1; end
        n_vec++; if (!seen) begin n_bad++; $display("FAIL read_timeout: got no m_valid want 1"); end
        n_vec++; if (m_data !== 8'h41) begin n_bad++; $display("FAIL read_data: got %h want 41", m_data); end
        n_vec++; if (m_err !== 1'b0) begin n_bad++; $display("FAIL read_err: got %b want 0", m_err); end
        tick(1);
        n_vec++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL read_valid_drop: got %b want 0", m_valid); end
        tick(20);
        n_vec++; if (rd_data_cnt - rd0 !== 1) begin n_bad++; $display("FAIL read_pops: got %0d want 1", rd_data_cnt - rd0); end
        n_vec++; if (valid_cyc - vc0 !== 1) begin n_bad++; $display("FAIL read_valid_cycles: got %0d want 1", valid_cyc - vc0); end
    endtask

    task automatic test_backpressure();
        int  rd0, wr0, bad;
        bit  seen;
        seen = 0; bad = 0;
        m_ready = 1'b0;
        ctrl_q.push_back(9'h003);
        data_q.push_back(9'h0AB);
        for (int i = 0; i < 40 && !seen; i++) begin tick(1); if (m_valid) seen = 1; end
        n_vec++; if (!seen) begin n_bad++; $display("FAIL bp_timeout: got no m_valid want 1"); end
        rd0 = rd_data_cnt + rd_ctrl_cnt; wr0 = wr_q.size();
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (!(m_valid === 1'b1 && m_data === 8'hAB && u_rden === 1'b0 && u_wren === 1'b0)) bad++;
        end
        n_vec++; if (bad !== 0) begin n_bad++; $display("FAIL bp_stable: got %0d bad cycles want 0", bad); end
        n_vec++; if ((rd_data_cnt + rd_ctrl_cnt - rd0) + (wr_q.size() - wr0) !== 0) begin n_bad++; $display("FAIL bp_bus_quiet: got %0d accesses want 0", (rd_data_cnt + rd_ctrl_cnt - rd0) + (wr_q.size() - wr0)); end
        m_ready = 1'b1;
        tick(1);
        n_vec++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL bp_accept: got %b want 0", m_valid); end
    endtask

    task automatic test_overrun();
        int rd0;
        logic [CNT_W-1:0] ovr0;
        wr_q.delete();
        rd0 = rd_data_cnt; ovr0 = ovr_cnt;
        ctrl_q.push_back(9'h007);
        data_q.push_back(9'h099);
        for (int i = 0; i < 40 && wr_q.size() < 1; i++) tick(1);
        n_vec++;
        if (wr_q.size() < 1) begin
            n_bad++; $display("FAIL ovr_timeout: got no write want 111/00");
        end else if ({wr_q[0].addr, wr_q[0].data} !== {3'b111, 8'h00}) begin
            n_bad++; $display("FAIL ovr_dis_wr: got %b/%h want 111/00", wr_q[0].addr, wr_q[0].data);
        end
        tick(1);
        n_vec++; if (ovr_cnt !== ovr0 + 8'd1) begin n_bad++; $display("FAIL ovr_cnt_inc: got %h want %h", ovr_cnt, ovr0 + 8'd1); end
        n_vec++; if (running !== 1'b0) begin n_bad++; $display("FAIL ovr_running: got %b want 0", running); end
        for (int i = 0; i < 40 && wr_q.size() < 2; i++) tick(1);
        n_vec++;
        if (wr_q.size() < 2) begin
            n_bad++; $display("FAIL ovr_reen_timeout: got %0d writes want 2", wr_q.size());
        end else begin
            if ({wr_q[1].addr, wr_q[1].data} !== {3'b111, 8'h01}) begin n_bad++; $display("FAIL ovr_reen_wr: got %b/%h want 111/01", wr_q[1].addr, wr_q[1].data); end
            n_vec++; if (wr_q[1].cyc - wr_q[0].cyc !== RECOVER_CYC + 1) begin n_bad++; $display("FAIL ovr_hold: got %0d want %0d", wr_q[1].cyc - wr_q[0].cyc, RECOVER_CYC + 1); end
        end
        n_vec++; if (rd_data_cnt !== rd0) begin n_bad++; $display("FAIL ovr_no_data_read: got %0d reads want 0", rd_data_cnt - rd0); end
        data_q.delete();
        tick(2);
        n_vec++; if (running !== 1'b1) begin n_bad++; $display("FAIL ovr_running_back: got %b want 1", running); end
    endtask

    task automatic test_frame_err();
        int  vc0;
        bit  seen;
        logic [CNT_W-1:0] err0;
        vc0 = valid_cyc; err0 = err_cnt; seen = 0;
        m_ready = 1'b1;
        ctrl_q.push_back(9'h003);
        data_q.push_back(9'h155);
        for (int i = 0; i < 40 && !seen; i++) begin tick(1); if (m_valid) seen = 1; end
`ifdef DROP_ERR_EN
        n_vec++; if (seen) begin n_bad++; $display("FAIL ferr_dropped: got m_valid=1 want 0"); end
`else
        n_vec++; if (!seen) begin n_bad++; $display("FAIL ferr_timeout: got no m_valid want 1"); end
        n_vec++; if ({m_err, m_data} !== 9'h155) begin n_bad++; $display("FAIL ferr_byte: got %h want 155", {m_err, m_data}); end
`endif
        tick(2);
        n_vec++; if (err_cnt !== err0 + 8'd1) begin n_bad++; $display("FAIL ferr_cnt: got %h want %h", err_cnt, err0 + 8'd1); end
`ifdef DROP_ERR_EN
        n_vec++; if (valid_cyc !== vc0) begin n_bad++; $display("FAIL ferr_no_valid: got %0d want 0", valid_cyc - vc0); end
`else
        n_vec++; if (valid_cyc - vc0 !== 1) begin n_bad++; $display("FAIL ferr_valid_once: got %0d want 1", valid_cyc - vc0); end
`endif
    endtask

    task automatic test_stop();
        int rc0;
        wr_q.delete();
        enable = 1'b0;
        for (int i = 0; i < 20 && wr_q.size() < 1; i++) tick(1);
        n_vec++;
        if (wr_q.size() < 1) begin
            n_bad++; $display("FAIL stop_timeout: got no write want 111/00");
        end else if ({wr_q[0].addr, wr_q[0].data} !== {3'b111, 8'h00}) begin
            n_bad++; $display("FAIL stop_wr: got %b/%h want 111/00", wr_q[0].addr, wr_q[0].data);
        end
        tick(1);
        n_vec++; if (running !== 1'b0) begin n_bad++; $display("FAIL stop_running: got %b want 0", running); end
        rc0 = rd_ctrl_cnt;
        tick(20);
        n_vec++; if (wr_q.size() !== 1 || rd_ctrl_cnt !== rc0) begin n_bad++; $display("FAIL stop_idle: got %0d writes %0d polls want 1 0", wr_q.size(), rd_ctrl_cnt - rc0); end
    endtask

    task automatic test_reset_midway();
        bit seen;
        seen = 0;
        enable = 1'b1;
        for (int i = 0; i < 40 && !seen; i++) begin tick(1); if (u_rden) seen = 1; end
        n_vec++; if (!seen) begin n_bad++; $display("FAIL mid_timeout: got no u_rden want 1"); end
        reset = 1'b1;
        #1;
        n_vec++; if ({u_rden, u_wren, running} !== 3'b000) begin n_bad++; $display("FAIL mid_strobes: got %b want 000", {u_rden, u_wren, running}); end
        n_vec++; if ({err_cnt, ovr_cnt} !== '0) begin n_bad++; $display("FAIL mid_cnts: got %h want 0", {err_cnt, ovr_cnt}); end
        @(negedge clk);
        ctrl_q.delete(); data_q.delete(); wr_q.delete();
        cfg_period = 8'h33;
        reset = 1'b0;
        for (int i = 0; i < 10 && wr_q.size() < 2; i++) tick(1);
        n_vec++;
        if (wr_q.size() < 2) begin
            n_bad++; $display("FAIL mid_cfg_timeout: got %0d writes want 2", wr_q.size());
        end else if ({wr_q[0].addr, wr_q[0].data, wr_q[1].addr, wr_q[1].data} !== {3'b100, 8'h33, 3'b111, 8'h01}) begin
            n_bad++; $display("FAIL mid_cfg: got %b/%h %b/%h want 100/33 111/01", wr_q[0].addr, wr_q[0].data, wr_q[1].addr, wr_q[1].data);
        end
    endtask

    task automatic test_ovr_sat();
        for (int i = 0; i < (1 << CNT_W) + 2; i++) ctrl_q.push_back(9'h007);
        for (int i = 0; i < 8000 && ctrl_q.size() > 0; i++) tick(1);
        n_vec++; if (ctrl_q.size() !== 0) begin n_bad++; $display("FAIL sat_timeout: got %0d polls left want 0", ctrl_q.size()); end
        tick(30);
        n_vec++; if (ovr_cnt !== 8'hFF) begin n_bad++; $display("FAIL sat_ovr_cnt: got %h want ff", ovr_cnt); end
        n_vec++; if (err_cnt !== 8'h00) begin n_bad++; $display("FAIL sat_err_cnt: got %h want 00", err_cnt); end
        n_vec++; if (both_cnt !== 0) begin n_bad++; $display("FAIL wr_rd_overlap: got %0d want 0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_config();
        test_read();
        test_backpressure();
        test_overrun();
        test_frame_err();
        test_stop();
        test_reset_midway();
        test_ovr_sat();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Sequencer that owns the register port of the UART receiver block. After reset it programs the baud period and sets RXEN, then polls the control register and drains received bytes through a valid/ready stream to a consumer. It recovers from overrun by cycling RXEN and keeps saturating frame-error and overrun counters. It sits between the UART receiver's addr/wren/rden/din/dout port and the downstream byte consumer.

Parameters:
- PERIOD_DEF, 8'h1A: period written at start when cfg_period is 0.
- POLL_GAP, 4: idle cycles between consecutive control-register polls (minimum 0).
- RECOVER_CYC, 8: cycles RXEN is held low during overrun recovery (minimum 1).
- CNT_W, 8: width of the error and overrun counters.

Ports:
- clk, input, 1: clock.
- reset, input, 1: asynchronous, active-high reset.
- enable, input, 1: run request; level-sensitive.
- cfg_period, input, 8: baud period to program; 0 selects PERIOD_DEF.
- u_addr, output, 3: receiver register address. 3'b100 = period, 3'b101 = rx data, 3'b111 = control.
- u_wren, output, 1: receiver write strobe.
- u_rden, output, 1: receiver read strobe.
- u_wdata, output, 8: receiver write data.
- u_rdata, input, 9: receiver read data. For control reads: bit0 RXEN, bit1 DATARDY, bit2 OVERRUN. For rx-data reads: [7:0] byte, [8] frame error.
- m_data, output, 8: delivered byte.
- m_err, output, 1: frame-error flag of the delivered byte.
- m_valid, output, 1: byte valid.
- m_ready, input, 1: consumer accept.
- running, output, 1: high while RXEN is programmed to 1.
- err_cnt, output, CNT_W: frame errors seen; saturates.
- ovr_cnt, output, CNT_W: overruns seen; saturates.

Behaviour:
- Reset: all outputs 0, u_addr 3'b000, state IDLE.
- Bus access rules:
  - A write is a single cycle with u_wren=1, u_addr and u_wdata valid.
  - A read takes two cycles. Cycle A: u_rden=1, u_addr set. Cycle B: u_rden=0, u_addr held, u_rdata registered at the end of cycle B.
  - u_wren and u_rden are never high together.
  - u_rden is high for exactly one cycle per read, because a read of 3'b101 pops the receiver FIFO.
- States:
  - IDLE: wait for enable=1, then go to CFG_P.
  - CFG_P: write 3'b100 with the effective period. Go to CFG_E.
  - CFG_E: write 3'b111 with 8'h01. Set running=1. Go to GAP.
  - GAP: count POLL_GAP cycles, then go to POLL_A. If POLL_GAP=0, go straight to POLL_A. If enable=0, go to STOP.
  - POLL_A / POLL_B: read the control register. On capture:
    - OVERRUN=1: go to OVR_DIS. OVERRUN takes priority over DATARDY; data pending in the FIFO is abandoned.
    - else DATARDY=1: go to RD_A.
    - else: go to GAP.
  - RD_A / RD_B: read 3'b101. Capture into m_data/m_err. If bit8=1, increment err_cnt. Go to DLV.
  - DLV: m_valid=1, with m_data/m_err stable until the cycle m_valid & m_ready. Then drop m_valid and go to GAP. No bus activity while in DLV.
  - OVR_DIS: write 3'b111 with 8'h00. Set running=0. Increment ovr_cnt. Go to OVR_WT.
  - OVR_WT: wait RECOVER_CYC cycles. If enable=1, go to CFG_E (period is not rewritten); otherwise go to IDLE.
  - STOP: write 3'b111 with 8'h00. Set running=0. Go to IDLE.
- enable is sampled only in GAP, OVR_WT and IDLE. A deassert during a read or during DLV completes that transaction first.
- Counters hold at all-ones; they clear only on reset.
- Throughput when the consumer is always ready: poll (2) + read (2) + deliver (1) + POLL_GAP cycles per byte.
- Reset mid-transaction: strobes drop immediately. The next enable re-runs the full configuration starting at CFG_P.

Optional Feature:
DROP_ERR_EN.
- Defined: a byte with bit8=1 still increments err_cnt but is not delivered; the controller goes from RD_B straight to GAP. m_err is tied to 0.
- Undefined: every byte is delivered, with m_err carrying its frame-error bit.

Test Plan:
1. reset, then enable=1 with cfg_period=0 → write (3'b100, 8'h1A), then write (3'b111, 8'h01) on the next cycle; running=1.
2. Control read returns 9'h003, then rx-data read returns 9'h041, m_ready=1 → exactly one u_rden pulse on 3'b101; m_data=8'h41, m_err=0, m_valid high for 1 cycle.
3. m_ready held 0 for 10 cycles with a byte pending → m_valid and m_data stable the whole time; no u_rden/u_wren until accept.
4. Control read returns 9'h007 → write (3'b111, 8'h00); ovr_cnt 0→1; RECOVER_CYC idle cycles; then write (3'b111, 8'h01); no rx-data read is issued.
5. Rx-data read returns 9'h155 → err_cnt increments. Without DROP_ERR_EN: m_data=8'h55, m_err=1. With DROP_ERR_EN: m_valid never rises.
6. enable dropped during GAP → write (3'b111, 8'h00), running=0, state IDLE. Also: 2^CNT_W+2 overruns → ovr_cnt holds at 8'hFF.
